timer_device: RTL and testbench

Programmable 32-bit countdown timer on the microsystem device bus; it responds to the device-window accesses the multi-cycle CPU controller issues when an address is above 0x7EFF. It holds three word registers (CTRL, PRESET, COUNT), counts down under a four-state FSM, and drives the interrupt request the controller samples in its IF, RF and WB states. It is the responder and interrupt source for the controller's device-write, device-read and interrupt handshake.

---
 rtl/timer_pkg.sv | 29 ++
 rtl/timer_device.sv | 115 +++++++++++
 tb/tb_timer_device.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - register map, FSM encoding and CTRL field layout for timer_device
package timer_pkg;

    localparam logic [15:0] BASE_ADDR = 16'h7F00;

    localparam logic [1:0] CTRL_OFF   = 2'd0;
    localparam logic [1:0] PRESET_OFF = 2'd1;
    localparam logic [1:0] COUNT_OFF  = 2'd2;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_LOAD = 2'b01;
    localparam logic [1:0] ST_CNT  = 2'b10;
    localparam logic [1:0] ST_INT  = 2'b11;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    localparam int CTRL_W        = 4;
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;

    // Reserved modes 1x fall back to one-shot, so only the exact reload code reloads.
    function automatic logic is_reload(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/timer_device.sv
// rtl/timer_device.sv - memory-mapped 32-bit countdown timer with maskable interrupt
module timer_device
    import timer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [31:0]       preset_q, preset_d;
    logic [31:0]       count_q, count_d;
    logic [1:0]        state_q, state_d;
    logic              pending_q, pending_d;

    logic       sel;
    logic [1:0] off;
    logic       wr_ctrl;
    logic       wr_preset;
    logic       unused_addr_bits;

    assign sel              = addr[15:4] == BASE_ADDR[15:4];
    assign off              = addr[3:2];
    assign wr_ctrl          = we && sel && (off == CTRL_OFF);
    assign wr_preset        = we && sel && (off == PRESET_OFF);
    assign unused_addr_bits = ^addr[1:0];

    always_comb begin
        ctrl_d    = ctrl_q;
        preset_d  = preset_q;
        count_d   = count_q;
        state_d   = state_q;
        pending_d = pending_q;

        if (wr_ctrl || wr_preset) begin
            pending_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[CTRL_EN_BIT]) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[CTRL_EN_BIT]) begin
                    state_d = ST_IDLE;
                end else if (count_q <= 32'd1) begin
                    // Placed after the write clear so a same-cycle CPU write cannot lose the event.
                    count_d   = 32'd0;
                    pending_d = 1'b1;
                    state_d   = ST_INT;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            ST_INT: begin
                if (is_reload(ctrl_q)) begin
                    pending_d = 1'b0;
                    state_d   = ST_LOAD;
                end else begin
                    ctrl_d[CTRL_EN_BIT] = 1'b0;
                    state_d             = ST_IDLE;
                end
            end
        endcase

        // CPU register writes override the hardware EN clear of a one-shot expiry.
        if (wr_ctrl) begin
            ctrl_d = wdata[CTRL_W-1:0];
        end
        if (wr_preset) begin
            preset_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q    <= '0;
            preset_q  <= '0;
            count_q   <= '0;
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (off)
                CTRL_OFF:   rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
                PRESET_OFF: rdata = preset_q;
                COUNT_OFF:  rdata = count_q;
                default:    rdata = '0;
            endcase
        end
    end

    assign irq = pending_q & ctrl_q[CTRL_IM_BIT];

endmodule

// File: tb/tb_timer_device.sv
// tb/tb_timer_device.sv - self-checking bench for timer_device against a timeline reference model
module tb_timer_device;

    localparam logic [15:0] A_CTRL = 16'h7F00;
    localparam logic [15:0] A_PRE  = 16'h7F04;
    localparam logic [15:0] A_CNT  = 16'h7F08;
    localparam logic [15:0] A_RSV  = 16'h7F0C;
    localparam logic [15:0] A_OUT  = 16'h7F10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] addr = A_CNT;
    logic        we = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    timer_device dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] d);
        addr = a;
        we   = 1'b0;
        #1;
        d = rdata;
    endtask

    // Write occupies the current cycle; returns at the next falling edge.
    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    // j=0 is the cycle after the CTRL write that set EN. Expected values follow from the
    // timeline: two cycles to LOAD, then max(P,1) counting cycles, then INT (and for reload,
    // a period of max(P,1)+2 cycles).
    task automatic run_check(input int p, input bit im, input bit reload, input int last_j,
                             input int mid_j, input logic [15:0] maddr, input logic [31:0] mdata);
        int          m;
        int          k;
        int          ph;
        int          exp_cnt;
        bit          exp_irq;
        logic [31:0] c;
        m = (p < 1) ? 1 : p;
        for (int j = 0; j <= last_j; j++) begin
            if (j > 0) begin
                if (j - 1 == mid_j) wr(maddr, mdata);
                else @(negedge clk);
            end
            exp_irq = 1'b0;
            exp_cnt = 0;
            k = j - 2;
            if (k >= 0) begin
                if (k < m) begin
                    exp_cnt = p - k;
                end else if (!reload) begin
                    exp_irq = im;
                end else begin
                    ph = (k - m) % (m + 2);
                    if (ph == 0) exp_irq = im;
                    else if (ph >= 2) exp_cnt = p - (ph - 2);
                end
            end
            rd(A_CNT, c);
            if (k >= 0) chk($sformatf("count p=%0d j=%0d", p, j), c, 32'(exp_cnt));
            chk($sformatf("irq p=%0d j=%0d", p, j), {31'b0, irq}, {31'b0, exp_irq});
        end
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] mpreset;
        logic [3:0]  mctrl;
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  cv;
        logic [1:0]  mode;
        bit          w;
        bit          im;
        int          p;
        int          m;
        logic [15:0] offs [4];

        offs[0] = A_CTRL; offs[1] = A_PRE; offs[2] = A_CNT; offs[3] = A_RSV;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd(offs[i], v);
            chk($sformatf("reset rd%0d", i), v, 32'h0);
        end
        chk("reset irq", {31'b0, irq}, 32'h0);

        // Register-file behaviour with EN kept low: random addresses, data and we.
        mctrl = '0;
        mpreset = '0;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0, 1, 2, 3: a = offs[$urandom_range(0, 3)] | 16'($urandom_range(0, 3));
                4:          a = A_OUT | 16'($urandom_range(0, 15));
                default:    a = 16'($urandom);
            endcase
            d = $urandom & 32'hFFFF_FFFE;
            w = 1'($urandom_range(0, 1));
            if (w) begin
                wr(a, d);
            end else begin
                addr = a; wdata = d; we = 1'b0;
                @(negedge clk);
            end
            if (w && a[15:4] == 12'h7F0) begin
                if (a[3:2] == 2'd0) mctrl = d[3:0];
                else if (a[3:2] == 2'd1) mpreset = d;
            end
            rd(A_CTRL, v); chk("reg ctrl", v, {28'b0, mctrl});
            rd(A_PRE, v);  chk("reg preset", v, mpreset);
            rd(A_CNT, v);  chk("reg count", v, 32'h0);
            rd(A_RSV, v);  chk("reg rsv", v, 32'h0);
            rd(a, v);
            chk("reg any", v, (a[15:4] != 12'h7F0) ? 32'h0 :
                              (a[3:2] == 2'd0) ? {28'b0, mctrl} :
                              (a[3:2] == 2'd1) ? mpreset : 32'h0);
            chk("reg irq", {31'b0, irq}, 32'h0);
        end
        wr(A_CTRL, 32'h0);

        // Directed one-shot, P=5: irq at t+8 and held.
        wr(A_PRE, 32'd5);
        wr(A_CTRL, 32'h9);
        run_check(5, 1'b1, 1'b0, 2 + 5 + 3, -1, A_CTRL, 32'h0);
        rd(A_CTRL, v); chk("oneshot ctrl", v, 32'h8);
        wr(A_CTRL, 32'h0);
        chk("oneshot clear irq", {31'b0, irq}, 32'h0);

        // Random one-shots including reserved modes and masked interrupt.
        for (int i = 0; i < 4; i++) begin
            p = $urandom_range(0, 12);
            m = (p < 1) ? 1 : p;
            case ($urandom_range(0, 2))
                0:       mode = 2'b00;
                1:       mode = 2'b10;
                default: mode = 2'b11;
            endcase
            im = 1'($urandom_range(0, 1));
            cv = {im, mode, 1'b1};
            wr(A_PRE, 32'(p));
            wr(A_CTRL, {28'b0, cv});
            run_check(p, im, 1'b0, 2 + m + 2, -1, A_CTRL, 32'h0);
            rd(A_CTRL, v); chk("rand oneshot ctrl", v, {28'b0, im, mode, 1'b0});
            wr(A_CTRL, 32'h0);
            chk("rand oneshot clear", {31'b0, irq}, 32'h0);
        end

        // Auto-reload, P=3 then random P, four periods each.
        wr(A_PRE, 32'd3);
        wr(A_CTRL, 32'hB);
        run_check(3, 1'b1, 1'b1, 2 + 3 + 4 * 5, -1, A_CTRL, 32'h0);
        wr(A_CTRL, 32'h0);
        repeat (4) @(negedge clk);
        chk("reload stop irq", {31'b0, irq}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            p = $urandom_range(0, 6);
            m = (p < 1) ? 1 : p;
            wr(A_PRE, 32'(p));
            wr(A_CTRL, 32'hB);
            run_check(p, 1'b1, 1'b1, 2 + m + 4 * (m + 2), -1, A_CTRL, 32'h0);
            wr(A_CTRL, 32'h0);
            repeat (4) @(negedge clk);
            chk("rand reload stop irq", {31'b0, irq}, 32'h0);
        end

        // Masked: count reaches 0, irq stays low, EN self-clears.
        wr(A_PRE, 32'd4);
        wr(A_CTRL, 32'h1);
        run_check(4, 1'b0, 1'b0, 2 + 4 + 3, -1, A_CTRL, 32'h0);
        rd(A_CTRL, v); chk("mask ctrl", v, 32'h0);

        // Pause at COUNT=7 (decrement edge still enabled), then restart from PRESET.
        wr(A_PRE, 32'd10);
        wr(A_CTRL, 32'h9);
        run_check(10, 1'b1, 1'b0, 5, -1, A_CTRL, 32'h0);
        wr(A_CTRL, 32'h8);
        for (int i = 0; i < 4; i++) begin
            rd(A_CNT, v); chk("pause count", v, 32'd6);
            chk("pause irq", {31'b0, irq}, 32'h0);
            @(negedge clk);
        end
        wr(A_CTRL, 32'h9);
        run_check(10, 1'b1, 1'b0, 2 + 10, -1, A_CTRL, 32'h0);
        wr(A_CTRL, 32'h0);

        // PRESET=0 fires at t+4.
        wr(A_PRE, 32'd0);
        wr(A_CTRL, 32'h9);
        run_check(0, 1'b1, 1'b0, 2 + 1 + 1, -1, A_CTRL, 32'h0);
        wr(A_CTRL, 32'h0);

        // PRESET rewrite during CNT leaves the running count alone.
        wr(A_PRE, 32'd6);
        wr(A_CTRL, 32'h9);
        run_check(6, 1'b1, 1'b0, 2 + 6 + 1, 4, A_PRE, 32'd100);
        rd(A_PRE, v); chk("preset rewrite", v, 32'd100);
        wr(A_CTRL, 32'h0);

        // Write outside the window during CNT changes nothing.
        wr(A_PRE, 32'd4);
        wr(A_CTRL, 32'h9);
        run_check(4, 1'b1, 1'b0, 2 + 4 + 1, 3, A_OUT, 32'h0);
        rd(A_CTRL, v); chk("outside write ctrl", v, 32'h8);
        wr(A_CTRL, 32'h0);

        // CTRL write in the one-shot INT cycle keeps EN and restarts.
        wr(A_PRE, 32'd2);
        wr(A_CTRL, 32'h9);
        run_check(2, 1'b1, 1'b0, 2 + 2, -1, A_CTRL, 32'h0);
        wr(A_CTRL, 32'h9);
        rd(A_CTRL, v); chk("int write ctrl", v, 32'h9);
        chk("int write irq", {31'b0, irq}, 32'h0);
        run_check(2, 1'b1, 1'b0, 2 + 2 + 1, -1, A_CTRL, 32'h0);
        wr(A_CTRL, 32'h0);

        // Reset with COUNT=2 aborts without an interrupt.
        wr(A_PRE, 32'd5);
        wr(A_CTRL, 32'h9);
        run_check(5, 1'b1, 1'b0, 5, -1, A_CTRL, 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int r = 0; r < 4; r++) begin
                rd(offs[r], v);
                chk($sformatf("post reset rd%0d", r), v, 32'h0);
            end
            chk("post reset irq", {31'b0, irq}, 32'h0);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
